// File: rtl/fir_mac_scheduler_if.sv
// Sample, coefficient and result signals for the shared-MAC FIR scheduler.
// The master drives samples and coefficient writes; the slave is the scheduler.
interface fir_mac_scheduler_if #(
  parameter int DW    = 24,
  parameter int CW    = 24,
  parameter int NTAPS = 8,
  parameter int NCH   = 2
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW  = $clog2(NTAPS);

  logic                 in_valid;
  logic                 in_ready;
  logic [CHW-1:0]       in_ch;
  logic signed [DW-1:0] in_data;
  logic                 coef_we;
  logic [TW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_wdata;
  logic                 coef_err;
  logic                 out_valid;
  logic [CHW-1:0]       out_ch;
  logic signed [DW-1:0] out_data;
  logic                 busy;

  modport master (
    output in_valid, in_ch, in_data, coef_we, coef_addr, coef_wdata,
    input  in_ready, coef_err, out_valid, out_ch, out_data, busy
  );

  modport slave (
    input  in_valid, in_ch, in_data, coef_we, coef_addr, coef_wdata,
    output in_ready, coef_err, out_valid, out_ch, out_data, busy
  );
endinterface

// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed FIR: one multiply-accumulate per cycle over NTAPS taps for
// NCH channels, with per-channel history, writable coefficients and saturation.
module fir_mac_scheduler #(
  parameter int DW    = 24,
  parameter int CW    = 24,
  parameter int NTAPS = 8,
  parameter int NCH   = 2,
  parameter int FRAC  = 23
) (
  input  logic               clk,
  input  logic               reset,
  fir_mac_scheduler_if.slave bus
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW  = $clog2(NTAPS);
  localparam int PW  = DW + CW;
  localparam int AW  = PW + $clog2(NTAPS);

  localparam logic signed [AW:0] RND  = {{(AW+1-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [AW:0] MAXV = {{(AW+2-DW){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW:0] MINV = {{(AW+2-DW){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_e;

  state_e               state_q, state_d;
  logic signed [CW-1:0] coef_q [NTAPS];
  logic signed [DW-1:0] hist_q [NCH][NTAPS];
  logic signed [AW-1:0] acc_q;
  logic [TW-1:0]        tap_q;
  logic [CHW-1:0]       ch_q;
  logic [CHW-1:0]       outCh_q;
  logic signed [DW-1:0] outData_q;
  logic                 coefErr_q;

  logic                 accept;
  logic                 chanOk;
  logic signed [PW-1:0] coefExt;
  logic signed [PW-1:0] histExt;
  logic signed [PW-1:0] prod;
  logic signed [AW:0]   rndSum;
  logic signed [AW:0]   rndShift;
  logic signed [DW-1:0] satVal;

  assign accept  = bus.in_valid && (state_q == IDLE);
  assign chanOk  = 32'(bus.in_ch) < NCH;
  assign coefExt = {{DW{coef_q[tap_q][CW-1]}}, coef_q[tap_q]};
  assign histExt = {{CW{hist_q[ch_q][tap_q][DW-1]}}, hist_q[ch_q][tap_q]};
  assign prod    = coefExt * histExt;

  // Round half up, then clamp into the output sample range.
  always_comb begin
    rndSum   = {acc_q[AW-1], acc_q} + RND;
    rndShift = rndSum >>> FRAC;
    if (rndShift > MAXV)      satVal = MAXV[DW-1:0];
    else if (rndShift < MINV) satVal = MINV[DW-1:0];
    else                      satVal = rndShift[DW-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Out-of-range channels are consumed without starting a computation.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && chanOk) state_d = MAC;
      MAC:     if (tap_q == TW'(NTAPS-1)) state_d = ROUND;
      ROUND:   state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.busy      = 1'b1;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
      end
      OUT:     bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.out_ch   = outCh_q;
  assign bus.out_data = outData_q;
  assign bus.coef_err = coefErr_q;

  // Coefficient writes land on the accept edge, so that sample sees them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NTAPS; k++) coef_q[k] <= '0;
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < NTAPS; k++) hist_q[c][k] <= '0;
      acc_q     <= '0;
      tap_q     <= '0;
      ch_q      <= '0;
      outCh_q   <= '0;
      outData_q <= '0;
      coefErr_q <= 1'b0;
    end else begin
      coefErr_q <= bus.coef_we && (state_q != IDLE);
      if (bus.coef_we && (state_q == IDLE)) coef_q[bus.coef_addr] <= bus.coef_wdata;
      case (state_q)
        IDLE: begin
          if (accept && chanOk) begin
            for (int k = NTAPS-1; k > 0; k--) hist_q[bus.in_ch][k] <= hist_q[bus.in_ch][k-1];
            hist_q[bus.in_ch][0] <= bus.in_data;
            ch_q  <= bus.in_ch;
            acc_q <= '0;
            tap_q <= '0;
          end
        end
        MAC: begin
          acc_q <= acc_q + {{(AW-PW){prod[PW-1]}}, prod};
          tap_q <= tap_q + TW'(1);
        end
        ROUND: begin
          outData_q <= satVal;
          outCh_q   <= ch_q;
        end
        default: ;
      endcase
    end
  end
endmodule
